flash_loader: RTL and testbench
===============================

FLASH_LOADER -- requirements
Module: flash_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 12: RAM word-address width.
REQ-002 SHALL have parameter DATA_W, default 16: flash/RAM word width.
REQ-003 SHALL have ports, one per line: name, direction, width, meaning. Clock and reset are listed first.
- CLK  input  1  single clock; all state changes on the rising edge.
- RST  input  1  synchronous, active-high reset.
- START  input  1  one-cycle pulse that requests an image load.
- FLASH_NEW_DATA  input  1  one-cycle pulse; FLASH_DATA is valid in the same cycle.
- FLASH_DATA  input  DATA_W  word streamed from the SPI flash reader.
- FLASH_IDLE  input  1  high = flash reader has stopped and will produce no more words.
- RAM_ADDR  output  ADDR_W  registered write address.
- RAM_DATA  output  DATA_W  registered write data.
- RAM_WREN  output  1  registered one-cycle write strobe.
- BUSY  output  1  high in S_HDR, S_LOAD and S_SUM.
- DONE  output  1  image loaded and checksum correct; core may run.
- ERR  output  1  load failed.
- WORDS  output  ADDR_W+1  count of payload words written so far.

Function
REQ-004 SHALL expect this image format: word 0 = length N; words 1..N = payload; word N+1 = checksum.
REQ-005 The checksum SHALL equal the sum of the payload words modulo 2^DATA_W.
REQ-006 SHALL implement the states S_IDLE, S_HDR, S_LOAD, S_SUM, S_DONE and S_ERR, one-hot or encoded.
REQ-007 S_IDLE: on START, go to S_HDR and clear WORDS, the address counter and the running sum.
REQ-008 In S_HDR, on FLASH_NEW_DATA, latch N from FLASH_DATA, then:
- N > 2^ADDR_W: go to S_ERR.
- N = 0: go to S_SUM.
- otherwise: go to S_LOAD.
REQ-009 In S_LOAD, each FLASH_NEW_DATA SHALL register the following, with RAM_WREN high for exactly the next cycle:
- RAM_ADDR = current address;
- RAM_DATA = FLASH_DATA;
- sum += FLASH_DATA, truncated to DATA_W;
- address += 1;
- WORDS += 1.
REQ-010 When WORDS reaches N (after the write of the last word), SHALL go to S_SUM; the address counter wraps to 0 only after word 2^ADDR_W, which is the last legal word.
REQ-011 In S_SUM, on FLASH_NEW_DATA: FLASH_DATA == sum goes to S_DONE, otherwise to S_ERR; no RAM write occurs.
REQ-012 In S_HDR, S_LOAD or S_SUM, FLASH_IDLE high with FLASH_NEW_DATA low SHALL go to S_ERR (flash exhausted early).
REQ-013 If FLASH_NEW_DATA and FLASH_IDLE are both high in the same cycle, the data word SHALL be consumed normally and FLASH_IDLE ignored for that cycle.
REQ-014 FLASH_NEW_DATA in S_IDLE, S_DONE or S_ERR SHALL be ignored: no write, no state change.
REQ-015 START while BUSY SHALL be ignored.
REQ-016 START in S_DONE or S_ERR SHALL restart the load per REQ-007 and deassert DONE/ERR on the next edge.
REQ-017 RAM_WREN SHALL be high only for the one cycle following a payload word; back-to-back FLASH_NEW_DATA pulses (every cycle) SHALL be supported without loss.
REQ-018 Latency: FLASH_NEW_DATA at edge k SHALL produce RAM_WREN/RAM_ADDR/RAM_DATA valid in cycle k+1; RAM commits on the falling edge of that cycle (RAM clocked by ~CLK).
REQ-019 DONE and ERR SHALL be registered, mutually exclusive, and held until START or RST.

Reset
REQ-020 On RST high at a rising edge, the block SHALL enter S_IDLE.
REQ-021 On reset, all outputs SHALL be 0: RAM_ADDR, RAM_DATA, RAM_WREN, BUSY, DONE, ERR, WORDS.
REQ-022 On reset, N, sum and the address counter SHALL be cleared.
REQ-023 RST SHALL take priority over START and FLASH_NEW_DATA in the same cycle.
REQ-024 RST mid-load SHALL abort immediately with no further RAM writes; RAM contents already written are left unchanged.

Verification
REQ-025 Nominal: START; stream words 3, 0x0001, 0x0002, 0xFFFF, 0x0002 (checksum) -> writes addr0=1, addr1=2, addr2=0xFFFF; then DONE=1, ERR=0, WORDS=3.
REQ-026 Bad checksum: same stream with checksum 0x0003 -> the 3 writes occur, then ERR=1 and DONE=0.
REQ-027 Early end: header 4, two payload words, then FLASH_IDLE=1 -> ERR=1 with exactly 2 writes.
REQ-028 Boundaries, covering three cases:
- header 0 then checksum 0 -> DONE with no writes;
- header 0x1001 -> ERR immediately;
- header 0x1000 with 4096 back-to-back words -> last write at addr 0xFFF, WORDS=0x1000.
REQ-029 Reset mid-op: RST after 2 of 5 payload words -> all outputs 0 next cycle and no further RAM_WREN; a later START with a fresh stream loads correctly from addr 0.
REQ-030 Simultaneous events, covering three cases:
- FLASH_NEW_DATA with FLASH_IDLE on the checksum word -> DONE;
- START during S_LOAD -> ignored;
- FLASH_NEW_DATA in S_DONE -> no write.

Source files
------------

// File: rtl/flash_loader.sv
// Streams a length-prefixed, checksummed image from the SPI flash reader into RAM.
// Word 0 = payload length N, words 1..N = payload, word N+1 = checksum (sum mod 2^DATA_W).
module flash_loader #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic              FLASH_NEW_DATA,
    input  logic [DATA_W-1:0] FLASH_DATA,
    input  logic              FLASH_IDLE,
    output logic [ADDR_W-1:0] RAM_ADDR,
    output logic [DATA_W-1:0] RAM_DATA,
    output logic              RAM_WREN,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERR,
    output logic [ADDR_W:0]   WORDS
);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_LOAD, S_SUM, S_DONE, S_ERR
    } state_t;

    // Header compare needs room for both the flash word and 2^ADDR_W.
    localparam int CMP_W = (DATA_W > ADDR_W + 1) ? DATA_W : ADDR_W + 1;

    state_t            state, state_nx;
    logic [ADDR_W:0]   n_len;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] sum;
    logic [ADDR_W:0]   words_inc;
    logic [CMP_W-1:0]  hdr_ext;
    logic [CMP_W-1:0]  n_limit;
    logic              restart;

    assign hdr_ext   = CMP_W'(FLASH_DATA);
    assign n_limit   = CMP_W'(1) << ADDR_W;
    assign words_inc = WORDS + (ADDR_W + 1)'(1);
    assign restart   = START && (state == S_IDLE || state == S_DONE || state == S_ERR);

    assign BUSY = (state == S_HDR) || (state == S_LOAD) || (state == S_SUM);
    assign DONE = (state == S_DONE);
    assign ERR  = (state == S_ERR);

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (START) state_nx = S_HDR;
            end
            S_HDR: begin
                if (FLASH_NEW_DATA) begin
                    if (hdr_ext > n_limit)      state_nx = S_ERR;
                    else if (hdr_ext == '0)     state_nx = S_SUM;
                    else                        state_nx = S_LOAD;
                end else if (FLASH_IDLE) begin
                    state_nx = S_ERR;
                end
            end
            S_LOAD: begin
                if (FLASH_NEW_DATA) begin
                    if (words_inc == n_len) state_nx = S_SUM;
                end else if (FLASH_IDLE) begin
                    state_nx = S_ERR;
                end
            end
            S_SUM: begin
                if (FLASH_NEW_DATA)  state_nx = (FLASH_DATA == sum) ? S_DONE : S_ERR;
                else if (FLASH_IDLE) state_nx = S_ERR;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= S_IDLE;
            n_len    <= '0;
            addr     <= '0;
            sum      <= '0;
            WORDS    <= '0;
            RAM_ADDR <= '0;
            RAM_DATA <= '0;
            RAM_WREN <= 1'b0;
        end else begin
            state    <= state_nx;
            RAM_WREN <= 1'b0;
            if (restart) begin
                addr  <= '0;
                sum   <= '0;
                WORDS <= '0;
            end
            if (state == S_HDR && FLASH_NEW_DATA) n_len <= hdr_ext[ADDR_W:0];
            // Address wraps to 0 only after the 2^ADDR_W-th word, which is also the last.
            if (state == S_LOAD && FLASH_NEW_DATA) begin
                RAM_WREN <= 1'b1;
                RAM_ADDR <= addr;
                RAM_DATA <= FLASH_DATA;
                sum      <= sum + FLASH_DATA;
                addr     <= addr + ADDR_W'(1);
                WORDS    <= words_inc;
            end
        end
    end

endmodule

// File: tb/tb_flash_loader.sv
// Scoreboard bench: stimulus queues expected RAM writes and final status; a monitor checks them.
module tb_flash_loader;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 16;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    typedef struct packed {
        logic          done;
        logic          err;
        logic [ADDR_W:0] words;
    } st_t;

    logic              CLK = 1'b0;
    logic              RST, START, FLASH_NEW_DATA, FLASH_IDLE;
    logic [DATA_W-1:0] FLASH_DATA;
    logic [ADDR_W-1:0] RAM_ADDR;
    logic [DATA_W-1:0] RAM_DATA;
    logic              RAM_WREN, BUSY, DONE, ERR;
    logic [ADDR_W:0]   WORDS;

    int n_chk  = 0;
    int n_fail = 0;

    wr_t wq[$];
    st_t sq[$];
    logic done_q = 1'b0;
    logic err_q  = 1'b0;

    flash_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .CLK(CLK), .RST(RST), .START(START),
        .FLASH_NEW_DATA(FLASH_NEW_DATA), .FLASH_DATA(FLASH_DATA), .FLASH_IDLE(FLASH_IDLE),
        .RAM_ADDR(RAM_ADDR), .RAM_DATA(RAM_DATA), .RAM_WREN(RAM_WREN),
        .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .WORDS(WORDS)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares every RAM write and every DONE/ERR assertion against the queues.
    always @(negedge CLK) begin
        if (RAM_WREN) begin
            if (wq.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected none at %0t",
                         RAM_ADDR, RAM_DATA, $time);
            end else begin
                wr_t e;
                e = wq.pop_front();
                chk("wr_addr", 32'(RAM_ADDR), 32'(e.addr));
                chk("wr_data", 32'(RAM_DATA), 32'(e.data));
            end
        end
        if ((DONE && !done_q) || (ERR && !err_q)) begin
            if (sq.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL unexpected_status: done %0b err %0b, expected no status at %0t",
                         DONE, ERR, $time);
            end else begin
                st_t s;
                s = sq.pop_front();
                chk("st_done",  32'(DONE),  32'(s.done));
                chk("st_err",   32'(ERR),   32'(s.err));
                chk("st_words", 32'(WORDS), 32'(s.words));
            end
        end
        done_q = DONE;
        err_q  = ERR;
    end

    task automatic tick();
        @(posedge CLK); #1;
    endtask

    task automatic send(input logic [DATA_W-1:0] w);
        FLASH_NEW_DATA = 1'b1;
        FLASH_DATA     = w;
        tick();
        FLASH_NEW_DATA = 1'b0;
    endtask

    task automatic start_pulse();
        START = 1'b1;
        tick();
        START = 1'b0;
    endtask

    task automatic expw(input int a, input int d);
        wq.push_back('{addr: ADDR_W'(a), data: DATA_W'(d)});
    endtask

    task automatic exps(input logic d, input logic e, input int w);
        sq.push_back('{done: d, err: e, words: (ADDR_W + 1)'(w)});
    endtask

    // Bounded wait for the monitor to consume everything queued.
    task automatic drain(input string name, input int max_cyc);
        for (int i = 0; i < max_cyc && (wq.size() != 0 || sq.size() != 0); i++) tick();
        chk({name, "_pending"}, 32'(wq.size() + sq.size()), 32'd0);
        wq.delete();
        sq.delete();
    endtask

    task automatic check_zero(input string name);
        chk({name, "_addr"},  32'(RAM_ADDR), 32'd0);
        chk({name, "_data"},  32'(RAM_DATA), 32'd0);
        chk({name, "_wren"},  32'(RAM_WREN), 32'd0);
        chk({name, "_busy"},  32'(BUSY),     32'd0);
        chk({name, "_done"},  32'(DONE),     32'd0);
        chk({name, "_err"},   32'(ERR),      32'd0);
        chk({name, "_words"}, 32'(WORDS),    32'd0);
    endtask

    initial begin
        logic [DATA_W-1:0] s, d;
        RST = 1'b1; START = 1'b0; FLASH_NEW_DATA = 1'b0; FLASH_DATA = '0; FLASH_IDLE = 1'b0;
        tick(); tick();
        RST = 1'b0;
        check_zero("reset");

        // Nominal image: 1 + 2 + 0xFFFF wraps to 0x0002.
        start_pulse();
        chk("busy_after_start", 32'(BUSY), 32'd1);
        expw(0, 16'h0001); expw(1, 16'h0002); expw(2, 16'hFFFF);
        exps(1'b1, 1'b0, 3);
        send(16'd3); send(16'h0001); send(16'h0002); send(16'hFFFF); send(16'h0002);
        drain("nominal", 10);

        // Bad checksum, restarted straight from S_DONE.
        start_pulse();
        chk("done_clears_on_start", 32'(DONE), 32'd0);
        expw(0, 16'h0001); expw(1, 16'h0002); expw(2, 16'hFFFF);
        exps(1'b0, 1'b1, 3);
        send(16'd3); send(16'h0001); send(16'h0002); send(16'hFFFF); send(16'h0003);
        drain("bad_sum", 10);

        // Flash runs dry after two of four payload words.
        start_pulse();
        expw(0, 16'hAAAA); expw(1, 16'h5555);
        exps(1'b0, 1'b1, 2);
        send(16'd4); send(16'hAAAA); send(16'h5555);
        FLASH_IDLE = 1'b1;
        tick();
        FLASH_IDLE = 1'b0;
        drain("early_end", 10);

        // Empty payload.
        start_pulse();
        exps(1'b1, 1'b0, 0);
        send(16'd0); send(16'd0);
        drain("len_zero", 10);

        // One word too long.
        start_pulse();
        exps(1'b0, 1'b1, 0);
        send(16'h1001);
        drain("len_over", 10);
        chk("len_over_busy", 32'(BUSY), 32'd0);

        // Full RAM, back-to-back words.
        start_pulse();
        exps(1'b1, 1'b0, 16'h1000);
        send(16'h1000);
        s = '0;
        for (int i = 0; i < 4096; i++) begin
            d = DATA_W'(i * 7 + 3);
            s = s + d;
            expw(i, d);
            send(d);
        end
        send(s);
        drain("full_ram", 20);
        chk("full_ram_last_addr", 32'(RAM_ADDR), 32'h0FFF);

        // Reset mid-load, colliding with START and a data word.
        start_pulse();
        expw(0, 16'h0011); expw(1, 16'h0022);
        send(16'd5); send(16'h0011); send(16'h0022);
        RST = 1'b1; START = 1'b1; FLASH_NEW_DATA = 1'b1; FLASH_DATA = 16'h0033;
        tick();
        RST = 1'b0; START = 1'b0; FLASH_NEW_DATA = 1'b0;
        check_zero("rst_mid");
        send(16'h0044);
        chk("rst_mid_no_wren", 32'(RAM_WREN), 32'd0);
        drain("rst_mid", 4);
        start_pulse();
        expw(0, 16'h0010); expw(1, 16'h0020);
        exps(1'b1, 1'b0, 2);
        send(16'd2); send(16'h0010); send(16'h0020); send(16'h0030);
        drain("reload", 10);

        // START during S_LOAD is ignored; IDLE alongside the checksum word is ignored.
        start_pulse();
        expw(0, 16'h0007);
        exps(1'b1, 1'b0, 1);
        send(16'd1);
        START = 1'b1;
        send(16'h0007);
        START = 1'b0;
        FLASH_IDLE = 1'b1;
        send(16'h0007);
        FLASH_IDLE = 1'b0;
        drain("simul", 10);

        // Data arriving in S_DONE must not write or change state.
        send(16'h0055);
        tick();
        chk("done_hold_done",  32'(DONE),  32'd1);
        chk("done_hold_err",   32'(ERR),   32'd0);
        chk("done_hold_words", 32'(WORDS), 32'd1);
        drain("done_hold", 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
